// File: rtl/stoch_chan_src.sv
// stoch_chan_src: channel-bit source for the stochastic decoder node array.
// Turns one quantized channel probability into a per-clock stochastic bit
// stream and supplies the pseudo-random SEL word used for edge-memory
// addressing. Each frame: load a probability, prime the edge memories, run
// the programmed number of decode cycles, then pulse DONE.
// Build option: SCS_SEPARATE_SEL_LFSR_EN gives SEL its own LFSR seeded with
// ~SEED; otherwise SEL is the comparator LFSR rotated by half its width.
module stoch_chan_src #(
  parameter int                LFSR_S  = 8,
  parameter int                PROB_W  = 8,
  parameter int                NCYC_W  = 16,
  parameter int                PRIME_N = 8,
  parameter logic [LFSR_S-1:0] SEED    = LFSR_S'(8'hA5)
) (
  input  logic              CLK,
  input  logic              INIT,
  input  logic              LOAD,
  input  logic [PROB_W-1:0] P_IN,
  input  logic [NCYC_W-1:0] NCYC,
  output logic              READY,
  output logic              c,
  output logic [LFSR_S-1:0] SEL,
  output logic              EM_INIT,
  output logic              BUSY,
  output logic              DONE
);

  // Feedback taps: x^8+x^6+x^5+x^4+1 or x^16+x^14+x^13+x^11+1.
  localparam logic [LFSR_S-1:0] TAPS =
    LFSR_S'((LFSR_S == 16) ? 16'hB400 : 16'h00B8);
  localparam int PCW = $clog2(PRIME_N + 1);

  // state | meaning
  // IDLE  | waiting for LOAD, READY high
  // PRIME | EM_INIT high for PRIME_N cycles
  // RUN   | decode cycles, cnt counts down to 1
  // FIN   | one-cycle DONE pulse
  typedef enum logic [1:0] {IDLE, PRIME, RUN, FIN} state_t;

  state_t              state_q, state_d;
  logic [LFSR_S-1:0]   lfsr_q;
  logic [PROB_W-1:0]   p_reg, p_next;
  logic [NCYC_W-1:0]   cnt_q;
  logic [PCW-1:0]      pcnt_q;
  logic                load_acc;
  logic                c_d;

  // Next-state decode and Moore outputs.
  always_comb begin
    state_d  = state_q;
    load_acc = 1'b0;
    READY    = 1'b0;
    EM_INIT  = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state_q)
      IDLE: begin
        READY = 1'b1;
        if (LOAD) begin
          load_acc = 1'b1;
          state_d  = PRIME;
        end
      end
      PRIME: begin
        EM_INIT = 1'b1;
        BUSY    = 1'b1;
        if (pcnt_q == '0) state_d = (cnt_q == '0) ? FIN : RUN;
      end
      RUN: begin
        BUSY = 1'b1;
        if (cnt_q == NCYC_W'(1)) state_d = FIN;
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The first c of a frame must already see the probability being loaded.
  always_comb begin
    p_next = load_acc ? P_IN : p_reg;
    c_d    = ((state_d == PRIME) || (state_d == RUN)) &&
             (lfsr_q[LFSR_S-1 -: PROB_W] < p_next);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (INIT) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Frame datapath: probability, cycle counters and the channel bit.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      p_reg  <= '0;
      cnt_q  <= '0;
      pcnt_q <= '0;
      c      <= 1'b0;
    end else begin
      c <= c_d;
      if (load_acc) begin
        p_reg  <= P_IN;
        cnt_q  <= NCYC;
        pcnt_q <= PCW'(PRIME_N - 1);
      end else begin
        if ((state_q == PRIME) && (pcnt_q != '0)) pcnt_q <= pcnt_q - PCW'(1);
        if (state_q == RUN) cnt_q <= cnt_q - NCYC_W'(1);
      end
    end
  end

  // Comparator LFSR: free-running in every state, reseeds if it ever locks at zero.
  always_ff @(posedge CLK) begin
    if (INIT || (lfsr_q == '0)) lfsr_q <= SEED;
    else                        lfsr_q <= {lfsr_q[LFSR_S-2:0], ^(lfsr_q & TAPS)};
  end

`ifdef SCS_SEPARATE_SEL_LFSR_EN
  logic [LFSR_S-1:0] sel_q;

  // Independent address LFSR so SEL is uncorrelated with the comparator draw.
  always_ff @(posedge CLK) begin
    if (INIT || (sel_q == '0)) sel_q <= ~SEED;
    else                       sel_q <= {sel_q[LFSR_S-2:0], ^(sel_q & TAPS)};
  end

  assign SEL = sel_q;
`else
  assign SEL = {lfsr_q[LFSR_S/2-1:0], lfsr_q[LFSR_S-1:LFSR_S/2]};
`endif

endmodule

// File: tb/tb_stoch_chan_src.sv
// tb_stoch_chan_src: directed bench for stoch_chan_src with default parameters.
module tb_stoch_chan_src;
  localparam int         PRIME_N = 8;
  localparam logic [7:0] SEED    = 8'hA5;

  logic        CLK  = 1'b0;
  logic        INIT = 1'b1;
  logic        LOAD = 1'b0;
  logic [7:0]  P_IN = '0;
  logic [15:0] NCYC = '0;
  logic        READY, c, EM_INIT, BUSY, DONE;
  logic [7:0]  SEL;

  int n_tests = 0;
  int n_fail  = 0;

  stoch_chan_src #(
    .LFSR_S(8), .PROB_W(8), .NCYC_W(16), .PRIME_N(PRIME_N), .SEED(SEED)
  ) dut (
    .CLK(CLK), .INIT(INIT), .LOAD(LOAD), .P_IN(P_IN), .NCYC(NCYC),
    .READY(READY), .c(c), .SEL(SEL), .EM_INIT(EM_INIT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Reference LFSR with taps 8,6,5,4 and zero guard.
  function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] sd);
    if (s == 8'h00) return sd;
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [7:0] m_lfsr, m_sel;
  always @(posedge CLK) begin
    m_lfsr <= INIT ? SEED  : step(m_lfsr, SEED);
    m_sel  <= INIT ? ~SEED : step(m_sel, ~SEED);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int em_hi, em_err, busy_err, ready_err, done_err, c_err, done_cnt, done_off, ones, run_zeros;

  // Runs one frame from the LOAD edge to the first IDLE cycle, scoring every cycle.
  task automatic run_frame(input logic [7:0] p, input logic [15:0] n, input bit spam);
    int last;
    logic [7:0] prev;
    bit em_e, busy_e, done_e, ready_e, c_e;
    last = PRIME_N + int'(n) + 2;
    em_hi = 0; em_err = 0; busy_err = 0; ready_err = 0; done_err = 0;
    c_err = 0; done_cnt = 0; done_off = -1; ones = 0; run_zeros = 0;
    P_IN = p; NCYC = n; LOAD = 1'b1;
    for (int off = 1; off <= last; off++) begin
      prev = m_lfsr;
      tick();
      if (spam) begin
        P_IN = 8'h33; NCYC = 16'd5; LOAD = (off < last);
      end else begin
        LOAD = 1'b0;
      end
      em_e    = (off <= PRIME_N);
      busy_e  = (off <= PRIME_N + int'(n));
      done_e  = (off == PRIME_N + int'(n) + 1);
      ready_e = (off == last);
      c_e     = busy_e && (prev < p);
      if (EM_INIT) em_hi++;
      if (EM_INIT !== em_e)   em_err++;
      if (BUSY    !== busy_e) busy_err++;
      if (READY   !== ready_e) ready_err++;
      if (DONE    !== done_e) done_err++;
      if (c       !== c_e)    c_err++;
      if (DONE === 1'b1) begin
        done_cnt++;
        if (done_off < 0) done_off = off;
      end
      if (off > PRIME_N && off <= PRIME_N + int'(n)) begin
        if (c === 1'b1) ones++;
        else            run_zeros++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int visits [256];
    logic [7:0] s0, v;
    int dup, seq_err, sel_err, sel_diff;

    // Reset
    INIT = 1'b1;
    tick(); tick();
    chk("rst_ready",   32'(READY),   1);
    chk("rst_c",       32'(c),       0);
    chk("rst_sel",     32'(SEL),     32'h5A);
    chk("rst_em_init", 32'(EM_INIT), 0);
    chk("rst_busy",    32'(BUSY),    0);
    chk("rst_done",    32'(DONE),    0);
    chk("rst_lfsr",    32'(dut.lfsr_q), 32'(SEED));

    // LFSR period: free run from SEED
    INIT = 1'b0;
    foreach (visits[i]) visits[i] = 0;
    s0 = dut.lfsr_q;
    visits[s0] = 1;
    dup = 0; seq_err = 0; sel_err = 0; sel_diff = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      v = dut.lfsr_q;
      if (v !== m_lfsr) seq_err++;
`ifdef SCS_SEPARATE_SEL_LFSR_EN
      if (SEL !== m_sel) sel_err++;
      if (SEL !== {v[3:0], v[7:4]}) sel_diff++;
`else
      if (SEL !== {v[3:0], v[7:4]}) sel_err++;
`endif
      if (i < 255) begin
        if (visits[v] != 0 || v == 8'h00) dup++;
        visits[v]++;
      end
    end
    chk("period_repeat", 32'(v), 32'(s0));
    for (int i = 1; i < 256; i++) if (visits[i] != 1) dup++;
    chk("period_unique", dup, 0);
    chk("lfsr_sequence", seq_err, 0);
    chk("sel_relation",  sel_err, 0);
`ifdef SCS_SEPARATE_SEL_LFSR_EN
    chk("sel_independent", 32'(sel_diff > 0), 1);
`endif

    // Reset mid-RUN: INIT sampled at the end of the 5th RUN cycle
    P_IN = 8'h80; NCYC = 16'd20; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int i = 2; i <= PRIME_N + 5; i++) tick();
    chk("abort_pre_busy", 32'(BUSY), 1);
    INIT = 1'b1;
    tick();
    INIT = 1'b0;
    chk("abort_busy",  32'(BUSY),  0);
    chk("abort_ready", 32'(READY), 1);
    chk("abort_c",     32'(c),     0);
    chk("abort_lfsr",  32'(dut.lfsr_q), 32'(SEED));
    chk("abort_preg",  32'(dut.p_reg), 0);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (DONE === 1'b1) done_cnt++;
      tick();
    end
    chk("abort_no_done", done_cnt, 0);

    // Nominal frame
    run_frame(8'h80, 16'd1000, 1'b0);
    chk("nom_em_cycles", em_hi, PRIME_N);
    chk("nom_em_shape",  em_err, 0);
    chk("nom_busy",      busy_err, 0);
    chk("nom_ready",     ready_err, 0);
    chk("nom_done_cnt",  done_cnt, 1);
    chk("nom_done_at",   done_off, PRIME_N + 1000 + 1);
    chk("nom_c_stream",  c_err, 0);
    chk("nom_ones_band", 32'(ones >= 460 && ones <= 540), 1);

    // Extremes
    run_frame(8'h00, 16'd300, 1'b0);
    chk("p0_ones",     ones, 0);
    chk("p0_c_stream", c_err, 0);
    chk("p0_done",     done_off, PRIME_N + 301);
    run_frame(8'hFF, 16'd300, 1'b0);
    chk("pff_zeros",    32'(run_zeros >= 1 && run_zeros <= 2), 1);
    chk("pff_c_stream", c_err, 0);

    // NCYC=0 with LOAD held high through the whole frame
    run_frame(8'hC0, 16'd0, 1'b1);
    chk("n0_em_cycles", em_hi, PRIME_N);
    chk("n0_done_at",   done_off, PRIME_N + 1);
    chk("n0_done_cnt",  done_cnt, 1);
    chk("n0_busy",      busy_err, 0);
    chk("n0_ready",     ready_err, 0);
    chk("n0_c_stream",  c_err, 0);
    chk("n0_preg",      32'(dut.p_reg), 32'hC0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stoch_chan_src.md
# stoch_chan_src

Upstream source for the equality-node array in the stochastic decoder. Converts one quantized channel probability into a per-clock stochastic bit stream `c` and generates the pseudo-random `SEL` word that nodes use for edge-memory addressing. A small FSM sequences each decode frame: accept a probability, prime the downstream edge memories, run a programmed number of decoding cycles, then report completion.

## Interface
- `LFSR_S`, default 8: LFSR width. Legal values are 8 and 16.
- `PROB_W`, default 8: channel probability width. Must satisfy PROB_W <= LFSR_S.
- `NCYC_W`, default 16: width of the decode cycle counter.
- `PRIME_N`, default 8: number of priming cycles. Matches the 3-bit EM address depth.
- `SEED`, default 8'hA5 (zero-extended): nonzero LFSR seed.
- `CLK  in  1`: clock. All logic is on the rising edge.
- `INIT  in  1`: reset. Synchronous, active-high.
- `LOAD  in  1`: probability valid strobe.
- `P_IN  in  PROB_W`: channel probability. Unsigned; bit value 1 corresponds to P(c=1) = P_IN / 2^PROB_W.
- `NCYC  in  NCYC_W`: number of run cycles. Sampled together with `P_IN`.
- `READY  out  1`: block can accept `LOAD`.
- `c  out  1`: registered stochastic channel bit.
- `SEL  out  LFSR_S`: registered address-selection word.
- `EM_INIT  out  1`: drives the nodes' initialization input during priming.
- `BUSY  out  1`: frame in progress.
- `DONE  out  1`: one-cycle pulse at the end of a frame.

## Operation
- Fibonacci LFSR, shifting every cycle in all states.
  - 8-bit feedback polynomial: x^8+x^6+x^5+x^4+1.
  - 16-bit feedback polynomial: x^16+x^14+x^13+x^11+1.
- If the LFSR state is ever all-zero, it reloads `SEED` on the next cycle.
- Comparator: next `c` = (LFSR[LFSR_S-1 -: PROB_W] < P_reg).
  - P_reg = 0 gives a constant 0.
  - `c` is held at 0 outside the PRIME and RUN states.
- FSM states and transitions:
  - IDLE: READY=1. When `LOAD`=1, capture P_reg <= P_IN and cnt <= NCYC, then go to PRIME.
  - PRIME: EM_INIT=1 and BUSY=1 for exactly PRIME_N cycles, then go to RUN.
  - RUN: BUSY=1; cnt decrements each cycle. The cycle on which cnt==1 is the last RUN cycle; the next state is FIN.
  - FIN: DONE=1 for one cycle, then return to IDLE.
- NCYC=0 at load: skip RUN and go from PRIME directly to FIN.
- `LOAD` while BUSY or in FIN: ignored. P_reg and cnt are unchanged.
- `INIT` overrides everything on the same edge, including mid-frame.
  - State returns to IDLE, LFSR returns to SEED, P_reg and cnt clear.
  - No DONE is issued for an aborted frame.
- Counter arithmetic is unsigned NCYC_W bits. A maximum NCYC value of all-ones runs 2^NCYC_W-1 cycles with no wrap.

## Timing
- Reset values: READY=1, c=0, SEL=SEED-derived value (see Configuration), EM_INIT=0, BUSY=0, DONE=0.
- `LOAD` sampled at edge k:
  - READY=0, BUSY=1 and EM_INIT=1 from k+1 through k+PRIME_N.
  - The first valid `c` appears at k+1, computed from LFSR state k and the new P_reg; `c` is valid during priming.
  - The RUN cycles are k+PRIME_N+1 through k+PRIME_N+NCYC.
  - DONE is high in the following cycle.
  - READY=1 one cycle after DONE.
- `c` and `SEL` are registered and change on the same edge. Downstream sees them as a coherent pair.
- Back-to-back frames: the minimum LOAD-to-LOAD spacing is PRIME_N+NCYC+2 cycles.

## Configuration
- `SCS_SEPARATE_SEL_LFSR_EN`:
  - Defined: `SEL` comes from a second LFSR of the same polynomial, seeded with ~SEED, with its own zero-lock guard. Comparator randomness and address randomness are independent.
  - Undefined: `SEL` is the comparator LFSR state rotated left by LFSR_S/2. No second register.
- Both builds have identical ports and FSM timing.

## Test plan
- Reset mid-RUN: load P_IN=8'h80, NCYC=20; assert INIT at the 5th RUN cycle. Required: next cycle BUSY=0, READY=1, c=0, LFSR=SEED, and no DONE.
- Nominal frame: P_IN=8'h80, NCYC=1000, LFSR_S=8. Required: EM_INIT high for exactly 8 cycles, count of c=1 over RUN within 500±40, a single DONE at cycle 1+8+1000+1.
- Extremes: P_IN=0 gives c=0 on every RUN cycle. P_IN=8'hFF gives c=0 only when LFSR[7:0]==8'hFF, i.e. at most once per 255-cycle period.
- NCYC=0 plus a LOAD pulsed every cycle during the frame. Required: PRIME_N priming cycles, DONE immediately after, extra LOADs ignored, P_reg unchanged.
- LFSR period: free-run 255 cycles (LFSR_S=8). Required: every nonzero state visited exactly once and the state repeats at cycle 255. Check both macro settings; with the macro defined, SEL must differ from the rotated comparator state.
